// File: rtl/t07_wb_rr_arbiter.sv
// Round-robin N-master Wishbone classic arbiter with a bus-timeout watchdog.
// The grant is held for a whole CYC; ack, err and read data go back to the owner only.
module t07_wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [DATA_W-1:0]               m_dat_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_adr_o,
  output logic [DATA_W-1:0]               s_dat_o,
  output logic [DATA_W/8-1:0]             s_sel_o,
  input  logic                            s_ack_i,
  input  logic [DATA_W-1:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            busy_o
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wdog_hit;
  logic [IDX_W-1:0]       cand;
  logic                   found;

  // Slave-side mux: AND-OR of the one-hot grant, so everything is 0 while idle.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      s_cyc_o = s_cyc_o | (m_cyc_i[k] & grant_q[k]);
      s_stb_o = s_stb_o | (m_stb_i[k] & grant_q[k]);
      s_we_o  = s_we_o  | (m_we_i[k]  & grant_q[k]);
      s_adr_o = s_adr_o | (m_adr_i[k*ADDR_W +: ADDR_W] & {ADDR_W{grant_q[k]}});
      s_dat_o = s_dat_o | (m_dat_i[k*DATA_W +: DATA_W] & {DATA_W{grant_q[k]}});
      s_sel_o = s_sel_o | (m_sel_i[k*SEL_W +: SEL_W] & {SEL_W{grant_q[k]}});
    end
  end

  // Ack in the same cycle suppresses the timeout.
  assign wdog_hit = (TIMEOUT != 0) && (state_q == BUSY) && s_stb_o && !s_ack_i
                    && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = grant_q & {NUM_MASTERS{wdog_hit}};
  assign m_dat_o = (state_q == BUSY) ? s_dat_i : '0;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    cand    = '0;
    found   = 1'b0;
    case (state_q)
      IDLE: begin
        // First requester at or above the pointer, wrapping around.
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          cand = IDX_W'((32'(ptr_q) + i) % NUM_MASTERS);
          if (!found && m_cyc_i[cand]) begin
            found   = 1'b1;
            gidx_d  = cand;
            grant_d = NUM_MASTERS'(1) << cand;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (wdog_hit || !m_cyc_i[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + IDX_W'(1);
        end else if (s_stb_o && !s_ack_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_t07_wb_rr_arbiter.sv
// Bench for t07_wb_rr_arbiter (4 masters, TIMEOUT=8): directed steps plus random traffic,
// every cycle compared with a bus-ownership model.
module tb_t07_wb_rr_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic          clk, nrst;
  logic [N-1:0]  cyc, stb, we;
  logic [31:0]   adr [N];
  logic [31:0]   dat [N];
  logic [3:0]    sel [N];
  logic          ack;
  logic [31:0]   sdat;

  logic [N*32-1:0] m_adr, m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic [31:0]     m_dat_o, s_adr_o, s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_cyc_o, s_stb_o, s_we_o, busy_o;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      m_adr[k*32 +: 32] = adr[k];
      m_dat[k*32 +: 32] = dat[k];
      m_sel[k*4 +: 4]   = sel[k];
    end
  end

  t07_wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(ack), .s_dat_i(sdat),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Model: which master owns the bus (-1 = nobody), next search start, unacked-strobe run length.
  int owner = -1;
  int ptr   = 0;
  int wd    = 0;
  int err_pulses = 0;
  logic [N-1:0] last_grant;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; ack = 1'b0; sdat = '0;
    for (int k = 0; k < N; k++) begin adr[k] = '0; dat[k] = '0; sel[k] = '0; end
  endtask

  // One bus cycle: called just after a falling edge with inputs already set.
  task automatic tick();
    int g;
    logic [N-1:0] eg;
    bit hit;
    #1;
    g   = owner;
    eg  = (g >= 0) ? N'(1 << g) : '0;
    hit = (g >= 0) && stb[g] && !ack && (wd + 1 == TMO);
    check("grant",  grant_o, eg);
    check("busy",   busy_o,  (g >= 0));
    check("s_cyc",  s_cyc_o, (g >= 0) ? cyc[g] : 1'b0);
    check("s_stb",  s_stb_o, (g >= 0) ? stb[g] : 1'b0);
    check("s_we",   s_we_o,  (g >= 0) ? we[g]  : 1'b0);
    check("s_adr",  s_adr_o, (g >= 0) ? adr[g] : 32'h0);
    check("s_dat",  s_dat_o, (g >= 0) ? dat[g] : 32'h0);
    check("s_sel",  s_sel_o, (g >= 0) ? sel[g] : 4'h0);
    check("m_ack",  m_ack_o, ack ? eg : '0);
    check("m_err",  m_err_o, hit ? eg : '0);
    check("m_dat",  m_dat_o, (g >= 0) ? sdat : 32'h0);
    last_grant = grant_o;
    if (m_err_o != '0) err_pulses++;
    @(posedge clk);
    if (g < 0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (ptr + i) % N;
        if (cyc[k]) begin owner = k; break; end
      end
      wd = 0;
    end else if (hit || !cyc[g]) begin
      owner = -1; ptr = (g + 1) % N; wd = 0;
    end else if (stb[g] && !ack) begin
      wd++;
    end else begin
      wd = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    owner = -1; ptr = 0; wd = 0;
  endtask

  initial begin
    int drop;
    int g;
    logic [N-1:0] prev;
    logic [N-1:0] seq [$];

    clear_inputs();
    nrst = 1'b0;
    #1;
    check("rst_grant", grant_o, '0);
    check("rst_busy", busy_o, 1'b0);
    do_reset();
    tick();

    // Master 0 write, slave acks on the second strobe cycle.
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h0000_1000; dat[0] = 32'hDEAD_BEEF; sel[0] = 4'hF;
    tick(); tick();
    ack = 1; tick();
    ack = 0; cyc[0] = 0; stb[0] = 0; tick(); tick(); tick();

    // Simultaneous 0/1 from reset, then again: rr alternation returns to 0.
    do_reset();
    cyc = 4'b0011; stb = 4'b0011;
    repeat (3) tick();
    cyc[0] = 0; stb[0] = 0;
    repeat (4) tick();
    cyc[1] = 0; stb[1] = 0; tick(); tick();
    cyc = 4'b0011; stb = 4'b0011;
    repeat (3) tick();
    check("rr_back_to_0", last_grant, 4'b0001);
    cyc = '0; stb = '0; tick(); tick();

    // Masters 1 and 3 contending, one access each: grants must alternate 1,3,1,3.
    do_reset();
    drop = -1; prev = '0;
    for (int n = 0; n < 16; n++) begin
      cyc = 4'b1010;
      if (drop >= 0) cyc[drop] = 1'b0;
      stb = cyc; ack = 1;
      g = owner;
      tick();
      if (last_grant != '0 && prev == '0) seq.push_back(last_grant);
      prev = last_grant;
      drop = g;
    end
    check("rr_len_ok", (seq.size() >= 4), 1'b1);
    for (int i = 0; i < 4; i++) check("rr_seq", seq[i], (i % 2 == 1) ? 4'b1000 : 4'b0010);
    clear_inputs(); tick(); tick();

    // Master 1 read.
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h0000_0040; sdat = 32'h1234_5678;
    tick(); tick();
    ack = 1; tick();
    check("rd_data", m_dat_o, 32'h1234_5678);
    ack = 0; cyc[1] = 0; stb[1] = 0; tick(); tick();

    // Slave never acks: exactly one err pulse, then forced release.
    err_pulses = 0;
    cyc[2] = 1; stb[2] = 1; adr[2] = 32'hBAD0_0000;
    repeat (10) tick();
    cyc[2] = 0; stb[2] = 0; tick(); tick();
    check("tmo_pulses", err_pulses, 1);

    // Ack lands on the 8th strobe cycle: no err.
    err_pulses = 0;
    cyc[2] = 1; stb[2] = 1;
    repeat (8) tick();
    ack = 1; tick();
    ack = 0; cyc[2] = 0; stb[2] = 0; tick(); tick();
    check("ack_wins", err_pulses, 0);

    // Async reset in the middle of a busy cycle.
    cyc[3] = 1; stb[3] = 1;
    tick(); tick();
    ack = 1;
    #2 nrst = 1'b0;
    #1;
    check("arst_grant", grant_o, '0);
    check("arst_cyc", s_cyc_o, 1'b0);
    check("arst_ack", m_ack_o, '0);
    check("arst_busy", busy_o, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    owner = -1; ptr = 0; wd = 0;
    ack = 0; cyc = 4'b1010; stb = 4'b1010;
    tick(); tick();
    check("post_rst_first", last_grant, 4'b0010);
    clear_inputs(); tick(); tick();

    // Random traffic with periodic slow-slave windows to provoke timeouts.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 6) == 0) cyc[k] = ~cyc[k];
        stb[k] = cyc[k] & ($urandom_range(0, 3) != 0);
        we[k]  = 1'($urandom);
        adr[k] = $urandom;
        dat[k] = $urandom;
        sel[k] = 4'($urandom);
      end
      ack  = (n % 200 < 40) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
      sdat = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
